// File: rtl/display_scan_ctrl_if.sv
// Load handshake between the value source and display_scan_ctrl.
// The master drives Valor/Carrega; the slave reports Ocupado/Estouro.
interface display_scan_ctrl_if #(
    parameter int DATA_W = 14
);
    logic [DATA_W-1:0] Valor;
    logic              Carrega;
    logic              Ocupado;
    logic              Estouro;

    modport master (
        output Valor,
        output Carrega,
        input  Ocupado,
        input  Estouro
    );

    modport slave (
        input  Valor,
        input  Carrega,
        output Ocupado,
        output Estouro
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Serial binary-to-BCD loader and multiplexed 7-segment digit scanner.
// LEADING_ZERO_BLANK_EN: blank leading zero digits at commit.
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    display_scan_ctrl_if.slave    ld,
    output logic [3:0]            Bcd_out,
    output logic [NUM_DIGITS-1:0] Anodos
);

    function automatic int ndig(input int w);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam int          NB    = ndig(DATA_W);
    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);
    localparam int          CW    = $clog2(DATA_W + 1);
    localparam int          PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int          IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t                      state;
    logic [DATA_W-1:0]           sh;
    logic [4*NB-1:0]             bcd;
    logic [4*NB-1:0]             adj;
    logic [CW-1:0]               cnt;
    logic                        ovf;
    logic [PW-1:0]               presc;
    logic [IW-1:0]               idx;
    logic [IW-1:0]               idx_nxt;
    logic                        tc;
    logic [3:0]                  dig_q   [NUM_DIGITS];
    logic [3:0]                  dig_nxt [NUM_DIGITS];
    logic [3:0]                  res     [NUM_DIGITS];
    logic [4*(NB+NUM_DIGITS)-1:0] bcd_w;
`ifdef LEADING_ZERO_BLANK_EN
    logic                        lead;
`endif

    // Zero-extend so digits beyond the accumulator width read as 0.
    assign bcd_w = {{(4*NUM_DIGITS){1'b0}}, bcd};
    assign tc    = (presc == PW'(SCAN_DIV - 1));

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
`endif
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            res[i] = bcd_w[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && res[i] == 4'h0 && i != 0) res[i] = 4'hF;
            else if (res[i] != 4'h0) lead = 1'b0;
`endif
        end
    end

    // Next digit contents feed Bcd_out so a commit shows up without delay.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_nxt[i] = dig_q[i];
            if (state == COMMIT) dig_nxt[i] = ovf ? 4'hF : res[i];
        end
    end

    always_comb begin
        idx_nxt = idx;
        if (tc) idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            sh         <= '0;
            bcd        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            ld.Ocupado <= 1'b0;
            ld.Estouro <= 1'b0;
            presc      <= '0;
            idx        <= '0;
            Bcd_out    <= 4'hF;
            Anodos     <= ~NUM_DIGITS'(1);
            for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= 4'hF;
        end else begin
            presc   <= tc ? '0 : presc + 1'b1;
            idx     <= idx_nxt;
            Anodos  <= ~(NUM_DIGITS'(1) << idx_nxt);
            Bcd_out <= dig_nxt[idx_nxt];
            for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= dig_nxt[i];
            unique case (state)
                IDLE: begin
                    if (ld.Carrega) begin
                        sh         <= ld.Valor;
                        bcd        <= '0;
                        cnt        <= '0;
                        ovf        <= (64'(ld.Valor) >= LIMIT);
                        ld.Ocupado <= 1'b1;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    {bcd, sh} <= {adj, sh} << 1;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    ld.Estouro <= ovf;
                    ld.Ocupado <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed testbench for display_scan_ctrl (4 digits, 14-bit value, SCAN_DIV=4).
// Expected digit sets are packed hex: digit 3 in [15:12], digit 0 in [3:0].
module tb_display_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 14;
    localparam int SD = 4;

    logic          clk;
    logic          rst;
    logic [3:0]    Bcd_out;
    logic [ND-1:0] Anodos;
    int            checks;
    int            errors;

    display_scan_ctrl_if #(.DATA_W(DW)) ld ();

    display_scan_ctrl #(
        .NUM_DIGITS(ND),
        .DATA_W    (DW),
        .SCAN_DIV  (SD)
    ) dut (
        .Clock  (clk),
        .Reset  (rst),
        .ld     (ld),
        .Bcd_out(Bcd_out),
        .Anodos (Anodos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] v, output int busy);
        ld.Valor   = v;
        ld.Carrega = 1'b1;
        tick(1);
        ld.Carrega = 1'b0;
        busy = 0;
        while (ld.Ocupado === 1'b1 && busy < 100) begin
            busy++;
            tick(1);
        end
    endtask

    task automatic get_digits(output logic [15:0] d, output logic ok);
        logic [3:0] seen;
        logic [3:0] oh;
        seen = '0;
        d    = '1;
        for (int c = 0; c < 40 && seen != 4'hF; c++) begin
            for (int i = 0; i < ND; i++) begin
                oh = 4'b0001 << i;
                if (Anodos === ~oh) begin
                    d[4*i +: 4] = Bcd_out;
                    seen[i]     = 1'b1;
                end
            end
            tick(1);
        end
        ok = (seen == 4'hF);
    endtask

    task automatic test_reset;
        int         idx;
        int         cnt;
        logic [3:0] exp_an;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++;
        if (ld.Ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_ocupado got %b want 0", ld.Ocupado);
        end
        checks++;
        if (ld.Estouro !== 1'b0) begin
            errors++;
            $display("FAIL reset_estouro got %b want 0", ld.Estouro);
        end
        checks++;
        if (Bcd_out !== 4'hF) begin
            errors++;
            $display("FAIL reset_bcd got %h want f", Bcd_out);
        end
        checks++;
        if (Anodos !== 4'b1110) begin
            errors++;
            $display("FAIL reset_anodos got %b want 1110", Anodos);
        end
        idx = 0;
        cnt = 0;
        for (int c = 0; c < 3 * ND * SD; c++) begin
            tick(1);
            cnt++;
            if (cnt == SD) begin
                cnt = 0;
                idx = (idx + 1) % ND;
            end
            exp_an = ~(4'b0001 << idx);
            checks++;
            if (Anodos !== exp_an || Bcd_out !== 4'hF || ld.Ocupado !== 1'b0) begin
                errors++;
                $display("FAIL scan_idle cyc %0d got an=%b bcd=%h oc=%b want an=%b bcd=f oc=0",
                         c, Anodos, Bcd_out, ld.Ocupado, exp_an);
            end
        end
    endtask

    task automatic test_load_1234;
        int          busy;
        logic [15:0] d;
        logic        ok;
        load(14'd1234, busy);
        checks++;
        if (busy != DW + 1) begin
            errors++;
            $display("FAIL busy_1234 got %0d want %0d", busy, DW + 1);
        end
        checks++;
        if (ld.Estouro !== 1'b0) begin
            errors++;
            $display("FAIL estouro_1234 got %b want 0", ld.Estouro);
        end
        get_digits(d, ok);
        checks++;
        if (!ok || d !== 16'h1234) begin
            errors++;
            $display("FAIL digits_1234 got %h ok=%b want 1234", d, ok);
        end
    endtask

    task automatic test_overflow;
        int          busy;
        logic [15:0] d;
        logic        ok;
        load(14'd10000, busy);
        checks++;
        if (ld.Estouro !== 1'b1) begin
            errors++;
            $display("FAIL estouro_10000 got %b want 1", ld.Estouro);
        end
        get_digits(d, ok);
        checks++;
        if (!ok || d !== 16'hFFFF) begin
            errors++;
            $display("FAIL digits_10000 got %h ok=%b want ffff", d, ok);
        end
        load(14'd9999, busy);
        checks++;
        if (ld.Estouro !== 1'b0) begin
            errors++;
            $display("FAIL estouro_9999 got %b want 0", ld.Estouro);
        end
        get_digits(d, ok);
        checks++;
        if (!ok || d !== 16'h9999) begin
            errors++;
            $display("FAIL digits_9999 got %h ok=%b want 9999", d, ok);
        end
        load(14'd16383, busy);
        checks++;
        if (ld.Estouro !== 1'b1) begin
            errors++;
            $display("FAIL estouro_16383 got %b want 1", ld.Estouro);
        end
        get_digits(d, ok);
        checks++;
        if (!ok || d !== 16'hFFFF) begin
            errors++;
            $display("FAIL digits_16383 got %h ok=%b want ffff", d, ok);
        end
    endtask

    task automatic test_back_to_back;
        int          busy;
        logic [15:0] d;
        logic [15:0] old;
        logic [3:0]  oh;
        logic [3:0]  exp_b;
        logic        ok;
        logic        hit;
        ld.Valor   = 14'd1234;
        ld.Carrega = 1'b1;
        tick(1);
        ld.Carrega = 1'b0;
        tick(4);
        ld.Valor   = 14'd5678;
        ld.Carrega = 1'b1;
        tick(1);
        ld.Carrega = 1'b0;
        busy = 5;
        while (ld.Ocupado === 1'b1 && busy < 100) begin
            busy++;
            tick(1);
        end
        checks++;
        if (busy != DW + 1) begin
            errors++;
            $display("FAIL busy_ignored got %0d want %0d", busy, DW + 1);
        end
        // Accept in the very cycle Ocupado falls; old digits must hold meanwhile.
        old        = 16'h1234;
        ld.Valor   = 14'd5678;
        ld.Carrega = 1'b1;
        tick(1);
        ld.Carrega = 1'b0;
        checks++;
        if (ld.Ocupado !== 1'b1) begin
            errors++;
            $display("FAIL accept_same_cycle got %b want 1", ld.Ocupado);
        end
        busy = 0;
        while (ld.Ocupado === 1'b1 && busy < 100) begin
            hit = 1'b0;
            exp_b = 4'hx;
            for (int i = 0; i < ND; i++) begin
                oh = 4'b0001 << i;
                if (Anodos === ~oh) begin
                    hit   = 1'b1;
                    exp_b = old[4*i +: 4];
                end
            end
            checks++;
            if (!hit || Bcd_out !== exp_b) begin
                errors++;
                $display("FAIL hold_during_conv cyc %0d got an=%b bcd=%h want %h",
                         busy, Anodos, Bcd_out, exp_b);
            end
            busy++;
            tick(1);
        end
        checks++;
        if (busy != DW + 1) begin
            errors++;
            $display("FAIL busy_5678 got %0d want %0d", busy, DW + 1);
        end
        get_digits(d, ok);
        checks++;
        if (!ok || d !== 16'h5678) begin
            errors++;
            $display("FAIL digits_5678 got %h ok=%b want 5678", d, ok);
        end
    endtask

    task automatic test_reset_mid;
        int          busy;
        logic [15:0] d;
        logic [15:0] exp_d;
        logic        ok;
        ld.Valor   = 14'd4321;
        ld.Carrega = 1'b1;
        tick(1);
        ld.Carrega = 1'b0;
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (ld.Ocupado !== 1'b0 || Bcd_out !== 4'hF || Anodos !== 4'b1110 ||
            ld.Estouro !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got oc=%b bcd=%h an=%b es=%b want 0 f 1110 0",
                     ld.Ocupado, Bcd_out, Anodos, ld.Estouro);
        end
        get_digits(d, ok);
        checks++;
        if (!ok || d !== 16'hFFFF) begin
            errors++;
            $display("FAIL digits_after_reset got %h ok=%b want ffff", d, ok);
        end
        load(14'd42, busy);
`ifdef LEADING_ZERO_BLANK_EN
        exp_d = 16'hFF42;
`else
        exp_d = 16'h0042;
`endif
        checks++;
        if (busy != DW + 1) begin
            errors++;
            $display("FAIL busy_42 got %0d want %0d", busy, DW + 1);
        end
        get_digits(d, ok);
        checks++;
        if (!ok || d !== exp_d) begin
            errors++;
            $display("FAIL digits_42 got %h ok=%b want %h", d, ok, exp_d);
        end
    endtask

    task automatic test_leading_zero;
        int          busy;
        logic [15:0] d;
        logic [15:0] exp7;
        logic [15:0] exp0;
        logic        ok;
`ifdef LEADING_ZERO_BLANK_EN
        exp7 = 16'hFFF7;
        exp0 = 16'hFFF0;
`else
        exp7 = 16'h0007;
        exp0 = 16'h0000;
`endif
        load(14'd7, busy);
        get_digits(d, ok);
        checks++;
        if (!ok || d !== exp7) begin
            errors++;
            $display("FAIL digits_7 got %h ok=%b want %h", d, ok, exp7);
        end
        load(14'd0, busy);
        get_digits(d, ok);
        checks++;
        if (!ok || d !== exp0) begin
            errors++;
            $display("FAIL digits_0 got %h ok=%b want %h", d, ok, exp0);
        end
        load(14'd1005, busy);
        get_digits(d, ok);
        checks++;
        if (!ok || d !== 16'h1005) begin
            errors++;
            $display("FAIL digits_1005 got %h ok=%b want 1005", d, ok);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        ld.Valor   = '0;
        ld.Carrega = 1'b0;
        test_reset();
        test_load_1234();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_leading_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Sequencer that shares a single combinational BCD-to-7-segment decoder across NUM_DIGITS multiplexed display digits.
- Accepts a binary value through a load handshake and converts it to BCD serially (shift-add-3, one bit per cycle).
- Holds the digits in registers and time-multiplexes them onto the shared decoder input while driving active-low digit enables.
- Sits between the accumulator/output register and the board display.

Parameters:
NUM_DIGITS, 4, number of display digits scanned (1..8)
DATA_W, 14, width of binary input value
SCAN_DIV, 50000, Clock cycles each digit stays active (>=1)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Valor  input  DATA_W  unsigned binary value to display
Carrega  input  1  load strobe; sampled only when Ocupado=0
Ocupado  output  1  conversion in progress; Carrega ignored while high
Estouro  output  1  last committed value was >= 10**NUM_DIGITS
Bcd_out  output  4  BCD code to shared decoder input; 4'hF = blank (decoder default output 1111111)
Anodos  output  NUM_DIGITS  digit enables, active-low, exactly one bit low

Behaviour:
- Reset values, all registered:
  - Ocupado=0, Estouro=0.
  - All digit registers 4'hF; Bcd_out=4'hF.
  - Scan index=0, Anodos=~1 (digit 0 low), prescaler=0, FSM=IDLE.
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - Carrega=1 captures Valor into the shift register, clears the BCD accumulator and bit counter.
  - Next state CONV; Ocupado=1 from the next cycle.
- CONV:
  - Each cycle: every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1.
  - Exactly DATA_W cycles, then COMMIT.
- COMMIT (1 cycle):
  - If the captured value >= 10**NUM_DIGITS: all digit registers load 4'hF and Estouro=1.
  - Otherwise the low NUM_DIGITS nibbles load the digit registers (digit 0 = units) and Estouro=0.
  - Next state IDLE; Ocupado=0 the following cycle.
- Latency and display update:
  - Ocupado is high for exactly DATA_W+1 cycles per accepted load.
  - New digits are visible on Bcd_out from the cycle after COMMIT.
  - Displayed digits hold the previous value throughout conversion; no intermediate values are ever shown.
- Carrega while Ocupado=1 is ignored, not queued.
- Carrega is accepted in the same cycle Ocupado falls back to 0 (the IDLE cycle).
- Internal BCD accumulator width: enough nibbles to hold 2**DATA_W-1. Overflow is compared against a compile-time constant.
- Scan:
  - Prescaler runs continuously, independent of the FSM, counting 0..SCAN_DIV-1.
  - On terminal count it wraps to 0 and the scan index advances; index NUM_DIGITS-1 wraps to 0.
  - Anodos = ~(1<<index); Bcd_out = digit_reg[index].
  - Both are registered and change together on the same edge.
- Simultaneous COMMIT and scan advance: Bcd_out shows the new index with the new digit data.
- Reset mid-conversion: the conversion is aborted and all state returns to reset values; display goes blank.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: at COMMIT, zero nibbles above the most significant nonzero digit load 4'hF (blank). Digit 0 always shows its value, so 0 displays as a single "0".
- Undefined: all NUM_DIGITS digits show their BCD value, including leading zeros.
- Overflow blanking applies in both builds.

Test Plan:
- Reset, then run 3*NUM_DIGITS*SCAN_DIV cycles -> Anodos cycles 1110,1101,1011,0111,1110 every SCAN_DIV cycles; Bcd_out=F throughout; Ocupado=0.
- SCAN_DIV=4; Valor=1234, Carrega pulse -> Ocupado high exactly 15 cycles; Bcd_out then shows 4,3,2,1 for Anodos 1110,1101,1011,0111; Estouro=0.
- Valor=10000 (NUM_DIGITS=4) -> Estouro=1, all digits F; then Valor=9999 -> Estouro=0, digits 9,9,9,9.
- Load 1234; pulse Carrega with Valor=5678 on conversion cycle 5 -> ignored, display 1234; after Ocupado falls, load 5678 -> display 5678.
- Reset asserted on conversion cycle 7 of a 4321 load -> the cycle after reset: Ocupado=0, all digits F, Anodos=1110; a new load of 42 completes normally.
- Valor=7: with LEADING_ZERO_BLANK_EN digits (3..0) = F,F,F,7; without it 0,0,0,7. Valor=0 with the macro -> F,F,F,0.
